// File: rtl/regmem_axil_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regmem_axil_arbiter
//  Purpose  : Round-robin arbiter/sequencer that shares the single AXI-lite
//             slave port of the register memory among NUM_REQ requesters.
//             One single-word transaction is in flight at a time; the
//             response is routed back to the requester that issued it.
//  Ports    : clk, reset_n (async, active low)
//             req_valid/req_ready/req_write/req_addr/req_wdata : requesters
//             rsp_valid/rsp_rdata/rsp_resp                     : responses
//             busy                                             : in flight
//             aw*/w*/b*/ar*/r*                                 : AXI-lite master
//  Options  : REGMEM_ADDR_CHECK_EN - reject addresses outside the register
//             map (3000..36767) locally with SLVERR, without an AXI access.
//  Revision : 1.0 - initial release
// ============================================================================
module regmem_axil_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 32,
    parameter int ID_SIZE   = 32
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ*ADDR_SIZE-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_SIZE-1:0]           rsp_rdata,
    output logic [1:0]                     rsp_resp,
    output logic                           busy,
    output logic                           awvalid,
    input  logic                           awready,
    output logic [ADDR_SIZE-1:0]           awaddr,
    output logic [ID_SIZE-1:0]             awid,
    output logic                           wvalid,
    input  logic                           wready,
    output logic [DATA_SIZE-1:0]           wdata,
    input  logic                           bvalid,
    output logic                           bready,
    input  logic [1:0]                     bresp,
    input  logic [ID_SIZE-1:0]             bid,
    output logic                           arvalid,
    input  logic                           arready,
    output logic [ADDR_SIZE-1:0]           araddr,
    output logic [ID_SIZE-1:0]             arid,
    input  logic                           rvalid,
    output logic                           rready,
    input  logic [DATA_SIZE-1:0]           rdata,
    input  logic [1:0]                     rresp,
    input  logic [ID_SIZE-1:0]             rid
);

    localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_WR_ADDR = 3'd1;
    localparam logic [2:0] c_WR_RESP = 3'd2;
    localparam logic [2:0] c_RD_ADDR = 3'd3;
    localparam logic [2:0] c_RD_RESP = 3'd4;

    localparam logic [1:0] c_SLVERR = 2'b10;

    logic [2:0]           r_state;
    logic [c_IDX_W-1:0]   r_ptr;
    logic [c_IDX_W-1:0]   r_gnt;
    logic [ADDR_SIZE-1:0] r_addr;
    logic [DATA_SIZE-1:0] r_wdata;
    logic                 r_awvalid;
    logic                 r_wvalid;
    logic                 r_bready;
    logic                 r_arvalid;
    logic                 r_rready;
    logic [NUM_REQ-1:0]   r_rsp_valid;
    logic [DATA_SIZE-1:0] r_rsp_rdata;
    logic [1:0]           r_rsp_resp;

    logic                 w_gnt_vld;
    logic [c_IDX_W-1:0]   w_gnt;
    logic                 w_accept;
    logic                 w_gnt_write;
    logic [ADDR_SIZE-1:0] w_gnt_addr;
    logic [DATA_SIZE-1:0] w_gnt_wdata;
    logic                 w_addr_ok;
    logic [NUM_REQ-1:0]   w_gnt_oh;
    logic [NUM_REQ-1:0]   w_cur_oh;

    // Search starts one past the last grant. r_ptr resets to the last index
    // so that the first search after reset begins at requester 0.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_gnt_vld && req_valid[c_IDX_W'((int'(r_ptr) + k) % NUM_REQ)]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = c_IDX_W'((int'(r_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign w_accept    = (r_state == c_IDLE) && w_gnt_vld;
    assign w_gnt_write = req_write[w_gnt];
    assign w_gnt_addr  = req_addr[w_gnt*ADDR_SIZE +: ADDR_SIZE];
    assign w_gnt_wdata = req_wdata[w_gnt*DATA_SIZE +: DATA_SIZE];
    assign w_gnt_oh    = NUM_REQ'(1) << w_gnt;
    assign w_cur_oh    = NUM_REQ'(1) << r_gnt;

`ifdef REGMEM_ADDR_CHECK_EN
    // Output-port, CRC and connection-config tables are contiguous, so a
    // single window covers the whole register map.
    localparam logic [ADDR_SIZE-1:0] c_MAP_LO = ADDR_SIZE'(3000);
    localparam logic [ADDR_SIZE-1:0] c_MAP_HI = ADDR_SIZE'(36767);
    assign w_addr_ok = (w_gnt_addr >= c_MAP_LO) && (w_gnt_addr <= c_MAP_HI);
`else
    assign w_addr_ok = 1'b1;
`endif

    // Accept is combinational with req_valid; gate it so nothing is accepted
    // while reset is held.
    assign req_ready = (w_accept && reset_n) ? w_gnt_oh : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= c_IDLE;
            r_ptr       <= c_IDX_W'(NUM_REQ - 1);
            r_gnt       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= '0;
        end else begin
            r_rsp_valid <= '0;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_ptr   <= w_gnt;
                        r_gnt   <= w_gnt;
                        r_addr  <= w_gnt_addr;
                        r_wdata <= w_gnt_wdata;
                        if (!w_addr_ok) begin
                            r_rsp_valid <= w_gnt_oh;
                            r_rsp_rdata <= '0;
                            r_rsp_resp  <= c_SLVERR;
                        end else if (w_gnt_write) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= c_WR_ADDR;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= c_RD_ADDR;
                        end
                    end
                end
                c_WR_ADDR: begin
                    // AW and W complete independently, in any order.
                    if (awready) r_awvalid <= 1'b0;
                    if (wready)  r_wvalid  <= 1'b0;
                    if ((!r_awvalid || awready) && (!r_wvalid || wready)) begin
                        r_bready <= 1'b1;
                        r_state  <= c_WR_RESP;
                    end
                end
                c_WR_RESP: begin
                    if (bvalid) begin
                        r_bready    <= 1'b0;
                        r_rsp_valid <= w_cur_oh;
                        r_rsp_rdata <= '0;
                        r_rsp_resp  <= (bid != ID_SIZE'(r_gnt)) ? c_SLVERR : bresp;
                        r_state     <= c_IDLE;
                    end
                end
                c_RD_ADDR: begin
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= c_RD_RESP;
                    end
                end
                c_RD_RESP: begin
                    if (rvalid) begin
                        r_rready    <= 1'b0;
                        r_rsp_valid <= w_cur_oh;
                        r_rsp_rdata <= rdata;
                        r_rsp_resp  <= (rid != ID_SIZE'(r_gnt)) ? c_SLVERR : rresp;
                        r_state     <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign busy      = (r_state != c_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_resp  = r_rsp_resp;
    assign awvalid   = r_awvalid;
    assign awaddr    = r_addr;
    assign awid      = ID_SIZE'(r_gnt);
    assign wvalid    = r_wvalid;
    assign wdata     = r_wdata;
    assign bready    = r_bready;
    assign arvalid   = r_arvalid;
    assign araddr    = r_addr;
    assign arid      = ID_SIZE'(r_gnt);
    assign rready    = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_regmem_axil_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regmem_axil_arbiter
//  Purpose  : Self-checking bench for regmem_axil_arbiter: directed cases plus
//             randomized requesters/slave checked against a transaction-level
//             model of arbitration, AXI-lite phases and responses.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regmem_axil_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int IW = 32;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_write = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic [1:0]      rsp_resp;
    logic            busy;
    logic            awvalid, awready = 1'b0;
    logic [AW-1:0]   awaddr;
    logic [IW-1:0]   awid;
    logic            wvalid, wready = 1'b0;
    logic [DW-1:0]   wdata;
    logic            bvalid = 1'b0, bready;
    logic [1:0]      bresp = '0;
    logic [IW-1:0]   bid = '0;
    logic            arvalid, arready = 1'b0;
    logic [AW-1:0]   araddr;
    logic [IW-1:0]   arid;
    logic            rvalid = 1'b0, rready;
    logic [DW-1:0]   rdata = '0;
    logic [1:0]      rresp = '0;
    logic [IW-1:0]   rid = '0;

    regmem_axil_arbiter #(.NUM_REQ(N), .DATA_SIZE(DW), .ADDR_SIZE(AW), .ID_SIZE(IW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rid(rid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    // ---------------- transaction-level reference model ----------------
    bit          m_busy = 0, m_first = 1, m_wr = 0;
    int          m_ptr = 0, m_g = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, m_rdata = 0;
    logic [1:0]  m_resp = 0;
    logic [3:0]  m_pulse = 0;
    bit          m_aw_done = 0, m_w_done = 0, m_ar_done = 0;

    function automatic bit in_map(input logic [31:0] a);
        return (a >= 3000 && a <= 3099) || (a >= 3100 && a <= 3999) || (a >= 4000 && a <= 36767);
    endfunction

    function automatic bit forwarded(input logic [31:0] a);
`ifdef REGMEM_ADDR_CHECK_EN
        return in_map(a);
`else
        return 1'b1;
`endif
    endfunction

    function automatic int rr_pick(input logic [3:0] v, input bit first, input int last);
        int start;
        start = first ? 0 : (last + 1) % N;
        for (int k = 0; k < N; k++)
            if (v[(start + k) % N]) return (start + k) % N;
        return -1;
    endfunction

    function automatic int oh_idx(input logic [3:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(negedge clk) begin : compare
        logic       busy0, ea, ew, eb, ear, er;
        logic [3:0] exp_rdy, pulse_next;
        logic [31:0] a;
        int g;
        if (!reset_n) begin
            m_busy = 0; m_first = 1; m_ptr = 0; m_pulse = 0; m_rdata = 0; m_resp = 0;
            chk("reset_ctrl", {req_ready, rsp_valid, busy, awvalid, wvalid, bready, arvalid, rready}, 64'd0);
            chk("reset_rsp", {rsp_rdata, rsp_resp}, 64'd0);
            chk("reset_aw", {awaddr, awid}, 64'd0);
        end else begin
            busy0 = m_busy;
            chk("rsp_valid", rsp_valid, m_pulse);
            chk("rsp_rdata", rsp_rdata, m_rdata);
            chk("rsp_resp", rsp_resp, m_resp);
            chk("busy", busy, busy0);
            ea  = busy0 &&  m_wr && !m_aw_done;
            ew  = busy0 &&  m_wr && !m_w_done;
            eb  = busy0 &&  m_wr && m_aw_done && m_w_done;
            ear = busy0 && !m_wr && !m_ar_done;
            er  = busy0 && !m_wr && m_ar_done;
            chk("axi_ctrl", {awvalid, wvalid, bready, arvalid, rready}, {ea, ew, eb, ear, er});
            if (ea) begin chk("awaddr", awaddr, m_addr); chk("awid", awid, m_g); end
            if (ew) chk("wdata", wdata, m_wdata);
            if (ear) begin chk("araddr", araddr, m_addr); chk("arid", arid, m_g); end
            pulse_next = '0;
            if (ea && awready) m_aw_done = 1;
            if (ew && wready)  m_w_done  = 1;
            if (ear && arready) m_ar_done = 1;
            if (eb && bvalid) begin
                pulse_next[m_g] = 1'b1; m_rdata = 0;
                m_resp = (bid != 32'(m_g)) ? 2'b10 : bresp;
                m_busy = 0;
            end
            if (er && rvalid) begin
                pulse_next[m_g] = 1'b1; m_rdata = rdata;
                m_resp = (rid != 32'(m_g)) ? 2'b10 : rresp;
                m_busy = 0;
            end
            exp_rdy = '0;
            if (!busy0 && req_valid != 0) begin
                g = rr_pick(req_valid, m_first, m_ptr);
                exp_rdy[g] = 1'b1;
                m_ptr = g; m_first = 0; m_g = g;
                a = req_addr[g*AW +: AW];
                if (!forwarded(a)) begin
                    pulse_next[g] = 1'b1; m_rdata = 0; m_resp = 2'b10;
                end else begin
                    m_busy = 1; m_wr = req_write[g]; m_addr = a;
                    m_wdata = req_wdata[g*DW +: DW];
                    m_aw_done = 0; m_w_done = 0; m_ar_done = 0;
                end
            end
            chk("req_ready", req_ready, exp_rdy);
            m_pulse = pulse_next;
        end
    end

    // ---------------- AXI-lite slave ----------------
    // mode 0: zero-wait, 1: random, 2: AW/W/AR readies driven by the test
    int          sl_mode = 0;
    int          sl_bid_force = -1;
    logic [1:0]  sl_bresp = 0, sl_rresp = 0;
    logic [31:0] sl_rdata = 32'hCAFE0001;
    bit          sl_rsp_en = 1;

    initial forever begin
        @(posedge clk); #1;
        case (sl_mode)
            0: begin
                awready = 1; wready = 1; arready = 1; bvalid = 1; rvalid = 1;
                bid = (sl_bid_force >= 0) ? 32'(sl_bid_force) : 32'(m_g);
                rid = 32'(m_g); bresp = sl_bresp; rresp = sl_rresp; rdata = sl_rdata;
            end
            1: begin
                awready = 1'($urandom % 2); wready = 1'($urandom % 2); arready = 1'($urandom % 2);
                bvalid = ($urandom % 3) == 0; rvalid = ($urandom % 3) == 0;
                bresp = ($urandom % 4 == 0) ? 2'b10 : 2'b00;
                rresp = ($urandom % 4 == 0) ? 2'b10 : 2'b00;
                bid = ($urandom % 8 == 0) ? 32'($urandom % 4) : 32'(m_g);
                rid = ($urandom % 8 == 0) ? 32'($urandom % 4) : 32'(m_g);
                rdata = $urandom;
            end
            default: begin
                bvalid = sl_rsp_en; rvalid = sl_rsp_en;
                bid = 32'(m_g); rid = 32'(m_g); bresp = 0; rresp = 0; rdata = sl_rdata;
            end
        endcase
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d);
        req_write[i] = wr;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 0; req_valid = 0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        reset_n = 1;
    endtask

    task automatic wait_idle(input int max);
        bit done;
        done = 0;
        for (int c = 0; c < max && !done; c++) begin
            @(negedge clk);
            if (!busy && rsp_valid == 0) done = 1;
        end
        if (!done) timeout_fail("wait_idle");
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom % 5)
            0: return 3000 + $urandom % 100;
            1: return 3100 + $urandom % 900;
            2: return 4000 + $urandom % 32768;
            3: return $urandom % 3000;
            default: return 36768 + $urandom % 1000;
        endcase
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        int order[5];
        int exp_ord[5];
        int rcnt[4];
        int ng, nrsp, lat, npulse;
        bit seen_ar, got;

        exp_ord = '{0, 1, 2, 3, 0};
        do_reset();

        // Single write from requester 1, zero-wait slave.
        sl_mode = 0;
        @(posedge clk); #1;
        set_req(1, 1, 3005, 32'hDEADBEEF); req_valid = 4'b0010;
        @(negedge clk); chk("t1_accept", req_ready, 4'b0010);
        @(posedge clk); #1; req_valid = 0;
        @(negedge clk);
        chk("t1_awwvalid", {awvalid, wvalid}, 2'b11);
        chk("t1_awaddr", awaddr, 3005);
        chk("t1_awid", awid, 1);
        chk("t1_wdata", wdata, 32'hDEADBEEF);
        @(negedge clk); chk("t1_bready", bready, 1);
        @(negedge clk);
        chk("t1_rsp_valid", rsp_valid, 4'b0010);
        chk("t1_rsp", {rsp_rdata, rsp_resp}, 64'd0);
        wait_idle(20);

        // Round-robin with all requesters continuously valid after reset.
        do_reset();
        for (int i = 0; i < N; i++) begin set_req(i, 0, 4000 + i, 0); rcnt[i] = 0; end
        req_valid = 4'hF;
        ng = 0; nrsp = 0;
        for (int c = 0; c < 60 && ng < 5; c++) begin
            @(negedge clk);
            if (req_ready != 0) begin order[ng] = oh_idx(req_ready); ng++; end
            if (rsp_valid != 0 && nrsp < 4) begin rcnt[oh_idx(rsp_valid)]++; nrsp++; end
        end
        chk("rr_grants", ng, 5);
        for (int k = 0; k < 5; k++) chk("rr_order", order[k], exp_ord[k]);
        for (int i = 0; i < N; i++) chk("rr_rsp_per_req", rcnt[i], 1);
        @(posedge clk); #1; req_valid = 0;
        wait_idle(20);

        // Read from an unmapped address with an error response.
        sl_rresp = 2'b10; sl_rdata = 0;
        @(posedge clk); #1;
        set_req(2, 0, 100, 0); req_valid = 4'b0100;
        @(negedge clk); chk("t4_accept", req_ready, 4'b0100);
        @(posedge clk); #1; req_valid = 0;
        seen_ar = 0; got = 0; lat = 0;
        for (int c = 1; c <= 10 && !got; c++) begin
            @(negedge clk);
            if (arvalid) seen_ar = 1;
            if (rsp_valid != 0) begin got = 1; lat = c; end
        end
        if (!got) timeout_fail("t4_rsp");
        chk("t4_rsp_valid", rsp_valid, 4'b0100);
        chk("t4_rsp_resp", rsp_resp, 2'b10);
`ifdef REGMEM_ADDR_CHECK_EN
        chk("t4_latency", lat, 1);
        chk("t4_no_arvalid", seen_ar, 0);
`else
        chk("t4_latency", lat, 3);
        chk("t4_arvalid_seen", seen_ar, 1);
`endif
        sl_rresp = 0; sl_rdata = 32'hCAFE0001;
        wait_idle(20);

        // ID mismatch on the B channel.
        sl_bid_force = 3;
        @(posedge clk); #1;
        set_req(0, 1, 3050, 32'h55); req_valid = 4'b0001;
        @(negedge clk); chk("t5_accept", req_ready, 4'b0001);
        @(posedge clk); #1; req_valid = 0;
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (rsp_valid != 0) got = 1;
        end
        if (!got) timeout_fail("t5_rsp");
        chk("t5_rsp_resp", rsp_resp, 2'b10);
        sl_bid_force = -1;
        wait_idle(20);

        // Back-pressure: AW accepted three cycles before W.
        sl_mode = 2; sl_rsp_en = 1;
        @(posedge clk); #1;
        awready = 0; wready = 0;
        set_req(3, 1, 3100, 32'h12345678); req_valid = 4'b1000;
        @(negedge clk); chk("t3_accept", req_ready, 4'b1000);
        @(posedge clk); #1; req_valid = 0; awready = 1;
        @(negedge clk);
        @(posedge clk); #1; awready = 0;
        @(negedge clk); chk("t3_aw_dropped_w_held", {awvalid, wvalid}, 2'b01);
        @(posedge clk); #1;
        @(negedge clk); chk("t3_no_b_yet", bready, 0);
        @(posedge clk); #1; wready = 1;
        @(negedge clk); chk("t3_w_hs_cycle", {wvalid, bready}, 2'b10);
        @(posedge clk); #1; wready = 0;
        npulse = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp_valid != 0) npulse++;
        end
        chk("t3_single_rsp", npulse, 1);

        // Reset while a read waits in the response phase.
        sl_rsp_en = 0;
        @(posedge clk); #1;
        arready = 1;
        set_req(0, 0, 5000, 0); req_valid = 4'b0001;
        @(posedge clk); #1; req_valid = 0;
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (rready) got = 1;
        end
        if (!got) timeout_fail("t6_rready");
        for (int i = 0; i < N; i++) set_req(i, 0, 3000 + i, 0);
        req_valid = 4'hF;
        #2; reset_n = 0;
        #1; chk("t6_async_clear", {arvalid, rready, rsp_valid, busy, req_ready}, 64'd0);
        @(negedge clk);
        @(posedge clk); #1; reset_n = 1; arready = 0; sl_mode = 0; sl_rsp_en = 1;
        @(negedge clk); chk("t6_first_grant", req_ready, 4'b0001);
        @(posedge clk); #1; req_valid = 0;
        wait_idle(20);

        // Randomized traffic.
        sl_mode = 1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) set_req(i, 1'($urandom % 2), rand_addr(), $urandom);
            req_valid = 4'($urandom);
        end
        @(posedge clk); #1; req_valid = 0;
        sl_mode = 0;
        wait_idle(50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
